// File: rtl/bcd_cascade_display.sv
// Synchronises and filters a ripple-counter BCD units digit, cascades decade rollovers
// into upper BCD digits and scans the full count onto an active-low 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero upper digits.
module bcd_cascade_display #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned STABLE_CYC = 2,
   parameter int unsigned SCAN_DIV   = 1000
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [3:0]              units_in,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    carry_out,
   output logic                    ovf,
   output logic                    bcd_err,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg
);

   localparam int unsigned CNT_W  = $clog2(STABLE_CYC + 1);
   localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

   logic [3:0]            s1, s2, cand;
   logic [CNT_W-1:0]      cnt, cnt_nxt_c;
   logic                  accept_c, units_load_c, wrap_c;
   logic [NUM_DIGITS:1]   carry_c;
   logic [4*NUM_DIGITS-1:0] bcd_nxt_c;
   logic [SCAN_W-1:0]     scan_cnt;
   logic [IDX_W-1:0]      idx;
   logic [3:0]            sel_dig_c;
   logic                  blank_c;

   // Active-low {g,f,e,d,c,b,a} decode of one BCD digit
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   // Two-flop synchroniser plus stability filter state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1   <= 4'd0;
         s2   <= 4'd0;
         cand <= 4'd0;
         cnt  <= '0;
      end else begin
         s1   <= units_in;
         s2   <= s1;
         cand <= s2;
         cnt  <= cnt_nxt_c;
      end
   end

   // Acceptance fires on the edge where the run length reaches STABLE_CYC, once per run
   always_comb begin
      cnt_nxt_c = cnt;
      if (s2 != cand)
         cnt_nxt_c = CNT_W'(1);
      else if (cnt != CNT_W'(STABLE_CYC))
         cnt_nxt_c = cnt + CNT_W'(1);
      accept_c = (cnt_nxt_c == CNT_W'(STABLE_CYC)) &&
                 ((s2 != cand) || (cnt != CNT_W'(STABLE_CYC)));
      units_load_c = accept_c && (s2 <= 4'd9) && (s2 != bcd_out[3:0]);
      wrap_c       = units_load_c && (bcd_out[3:0] == 4'd9) && (s2 == 4'd0);
   end

   // Single-cycle carry cascade through the upper digits; clr overrides it
   always_comb begin
      bcd_nxt_c  = bcd_out;
      carry_c    = '0;
      carry_c[1] = wrap_c;
      if (units_load_c)
         bcd_nxt_c[3:0] = s2;
      for (int k = 1; k < int'(NUM_DIGITS); k++) begin
         if (carry_c[k]) begin
            if (bcd_out[4*k +: 4] == 4'd9) begin
               bcd_nxt_c[4*k +: 4] = 4'd0;
               carry_c[k+1]        = 1'b1;
            end else begin
               bcd_nxt_c[4*k +: 4] = bcd_out[4*k +: 4] + 4'd1;
            end
         end
      end
      if (clr)
         bcd_nxt_c[4*NUM_DIGITS-1:4] = '0;
   end

   // Count, carry pulse and sticky flags
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bcd_out   <= '0;
         carry_out <= 1'b0;
         ovf       <= 1'b0;
         bcd_err   <= 1'b0;
      end else begin
         bcd_out   <= bcd_nxt_c;
         carry_out <= carry_c[NUM_DIGITS] && !clr;
         if (clr)
            ovf <= 1'b0;
         else if (carry_c[NUM_DIGITS])
            ovf <= 1'b1;
         if (clr)
            bcd_err <= 1'b0;
         else if (accept_c && (s2 > 4'd9))
            bcd_err <= 1'b1;
      end
   end

   // Digit selected for the current scan slot
   always_comb begin
      sel_dig_c = 4'd0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (idx == IDX_W'(k))
            sel_dig_c = bcd_out[4*k +: 4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:1] lz_c;

   // lz_c[k]: digit k and every digit above it are zero; units never blank
   always_comb begin
      lz_c = '0;
      lz_c[NUM_DIGITS-1] = (bcd_out[4*NUM_DIGITS-1 -: 4] == 4'd0);
      for (int k = int'(NUM_DIGITS) - 2; k >= 1; k--)
         lz_c[k] = (bcd_out[4*k +: 4] == 4'd0) && lz_c[k+1];
      blank_c = 1'b0;
      for (int k = 1; k < int'(NUM_DIGITS); k++) begin
         if (idx == IDX_W'(k))
            blank_c = lz_c[k];
      end
   end
`else
   assign blank_c = 1'b0;
`endif

   // Scan timing and registered anode/segment drive
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= '1;
         seg      <= 7'h7F;
      end else begin
         if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (idx == IDX_W'(NUM_DIGITS - 1))
               idx <= '0;
            else
               idx <= idx + IDX_W'(1);
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
         an  <= ~(NUM_DIGITS'(1) << idx);
         seg <= blank_c ? 7'h7F : seg_decode(sel_dig_c);
      end
   end

endmodule
